buart_fifo: RTL and testbench
=============================

Name: buart_fifo

Overview:
- Parametrised successor to the single-channel 8N1 UART: configurable baud divider and independent power-of-two RX and TX FIFOs.
- Adds glitch-rejecting start detection, a synchronised RX input and sticky overrun/framing error flags.
- Sits between the CPU I/O bus (single-cycle `wr`/`rd` strobes) and the board serial pins.

Parameters:
- FREQ_MHZ, 12: system clock frequency in MHz.
- BAUDS, 115200: line rate. DIV = FREQ_MHZ*1000000/BAUDS (integer division), DIV >= 4.
- RX_DEPTH_LOG2, 3: RX FIFO depth = 2**RX_DEPTH_LOG2 bytes. Range 1..8.
- TX_DEPTH_LOG2, 3: TX FIFO depth = 2**TX_DEPTH_LOG2 bytes. Range 1..8.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- resetq  input  1  asynchronous active-low reset.
- rx  input  1  serial input, asynchronous to clk.
- tx  output  1  serial output, idle high.
- wr  input  1  push tx_data into TX FIFO; ignored when busy=1.
- tx_data  input  8  byte to transmit.
- rd  input  1  pop RX FIFO head; ignored when valid=0.
- rx_data  output  8  RX FIFO head; meaningful only when valid=1.
- valid  output  1  RX FIFO non-empty.
- busy  output  1  TX FIFO full.
- tx_idle  output  1  TX FIFO empty and shifter idle.
- overrun  output  1  sticky: a received byte was dropped because the RX FIFO was full.
- frame_err  output  1  sticky: a stop bit was sampled low.
- parity_err  output  1  sticky parity mismatch; see Optional Feature.
- clr_err  input  1  clears all sticky flags next cycle.

Behaviour:
- Reset values (async assert, sync release):
  - tx=1, valid=0, busy=0, tx_idle=0, overrun=0, frame_err=0, parity_err=0.
  - All FIFO pointers 0; rx synchroniser flops 1.
- FIFOs:
  - Read/write pointers are (LOG2+1) bits wide; wrap naturally.
  - empty = pointers equal. full = MSBs differ and the low bits are equal.
  - rx_data is combinational from storage[rd_ptr]. Pop on rd takes effect next cycle.
- RX path:
  - rx passes through a 2-flop synchroniser; all references below use the synchronised value.
  - States: IDLE, START, DATA, STOP (STOP is preceded by PARITY when the optional feature is enabled). A bit counter runs 0..DIV-1.
  - IDLE: on low, go to START and clear the counter.
  - START: at count DIV/2-1, sample the line. Low: go to DATA and clear the counter. High: glitch, return to IDLE with no flags set.
  - DATA: sample at count DIV-1 and shift LSB first; after 8 samples go to STOP.
  - STOP: sample at count DIV-1.
    - Sample high: push the byte to the RX FIFO.
    - Sample low: set frame_err and discard the byte.
    - In both cases return to IDLE on the same cycle.
- RX push/pop:
  - Push when the FIFO is not full, or when full and rd=1 in the same cycle (read frees the slot first).
  - Otherwise drop the byte and set overrun.
  - Simultaneous push and pop on a non-full FIFO: both occur; count unchanged.
- TX path:
  - After reset the shifter first holds tx high for 15*DIV cycles (line settle); tx_idle=0 during this.
  - wr when not full: write at cycle n.
  - When the shifter is IDLE and the FIFO is non-empty it pops the head, loads {1,data,0} and enters SHIFT.
  - From wr into an empty FIFO with an idle shifter, tx goes low at cycle n+2.
  - SHIFT: each bit lasts exactly DIV cycles, 10 bits total (11 with parity). Then IDLE.
  - Back-to-back bytes: the next pop occurs on the cycle the previous stop bit ends, so there is no extra idle time between frames.
  - wr when busy=1: ignored, FIFO unchanged.
  - wr and pop in the same cycle on a full FIFO: wr is still ignored (busy is evaluated from the registered state).
- Errors:
  - clr_err has priority over a same-cycle set; that error event is lost.
- Reset mid-frame: tx returns to 1 immediately, the partial RX byte is discarded, and the 15-bit settle period reruns.

Optional Feature:
- BUART_PARITY_EN defined:
  - TX inserts an even-parity bit (XOR of the 8 data bits) between data and stop.
  - RX samples the PARITY state. On mismatch it sets parity_err and discards the byte, even if the stop bit is good.
  - Frame is 11 bits.
- Not defined: 8N1, 10-bit frame, parity_err tied to 0.

Test Plan:
- DIV=104, send 0x55 on rx with correct timing -> valid=1 within 10*104+3 cycles, rx_data=0x55; rd -> valid=0 next cycle.
- Write 0xA3 via wr after settle -> tx low 2 cycles later, then bits 1,1,0,0,0,1,0,1 each 104 cycles, stop high; tx_idle=1 after.
- Receive 9 bytes 0x00..0x08 with depth 8 and no rd -> valid=1, overrun=1, reads return 0x00..0x07; clr_err -> overrun=0.
- rx low pulse of 30 cycles -> no byte, no flags, FSM back in IDLE; frame with stop bit low, data 0x7E -> frame_err=1, FIFO unchanged.
- Write 9 bytes while the shifter is busy -> busy=1 after the 8th queued; 9th ignored; exactly 9 frames leave when the first was already in the shifter, else 8.
- With BUART_PARITY_EN: 0x07 sent with parity bit 0 -> parity_err=1, no push; with parity bit 1 -> rx_data=0x07.

Source files
------------

// File: rtl/buart_fifo.sv
// 8N1 UART with power-of-two RX/TX FIFOs, synchronised RX, glitch-rejecting start and sticky errors.
// Define BUART_PARITY_EN to add an even-parity bit (11-bit frame) on both directions.
module buart_fifo #(
    parameter int unsigned FREQ_MHZ      = 12,
    parameter int unsigned BAUDS         = 115200,
    parameter int unsigned RX_DEPTH_LOG2 = 3,
    parameter int unsigned TX_DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       rx,
    output logic       tx,
    input  logic       wr,
    input  logic [7:0] tx_data,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       valid,
    output logic       busy,
    output logic       tx_idle,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err,
    input  logic       clr_err
);
    localparam int unsigned Div     = FREQ_MHZ * 1000000 / BAUDS;
    localparam int unsigned Settle  = 15 * Div;
    localparam int unsigned Cw      = $clog2(Settle);
    localparam int unsigned RxDepth = 2 ** RX_DEPTH_LOG2;
    localparam int unsigned TxDepth = 2 ** TX_DEPTH_LOG2;
`ifdef BUART_PARITY_EN
    localparam int unsigned FrameBits = 11;
`else
    localparam int unsigned FrameBits = 10;
`endif
    localparam logic [Cw-1:0] DivLast    = Cw'(Div - 1);
    localparam logic [Cw-1:0] HalfLast   = Cw'(Div / 2 - 1);
    localparam logic [Cw-1:0] SettleLast = Cw'(Settle - 1);
    localparam logic [3:0]    LastBit    = 4'(FrameBits - 1);

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
    typedef enum logic [1:0] {TxSettle, TxIdle, TxShift} tx_state_e;

    // ---------------- RX FIFO ----------------
    logic [7:0]             rx_mem_q [RxDepth];
    logic [RX_DEPTH_LOG2:0] rx_wp_q, rx_rp_q;
    logic                   rx_empty, rx_full, rx_pop, rx_wr, rx_ovf;
    logic                   rx_s1_q, rx_s2_q;
    rx_state_e              rx_state_q;
    logic [Cw-1:0]          rx_cnt_q;
    logic [2:0]             rx_bits_q;
    logic [7:0]             rx_sh_q;
    logic                   rx_pbad_q, rx_push_q, rx_ferr_q, rx_perr_q;

    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[RX_DEPTH_LOG2] != rx_rp_q[RX_DEPTH_LOG2]) &&
                      (rx_wp_q[RX_DEPTH_LOG2-1:0] == rx_rp_q[RX_DEPTH_LOG2-1:0]);
    assign rx_pop   = rd && !rx_empty;
    // A same-cycle read frees the slot, so a full FIFO still accepts the byte.
    assign rx_wr    = rx_push_q && (!rx_full || rd);
    assign rx_ovf   = rx_push_q && rx_full && !rd;
    assign rx_data  = rx_mem_q[rx_rp_q[RX_DEPTH_LOG2-1:0]];
    assign valid    = !rx_empty;

    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem_q[rx_wp_q[RX_DEPTH_LOG2-1:0]] <= rx_sh_q;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_wp_q <= '0;
            rx_rp_q <= '0;
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            if (rx_wr)  rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop) rx_rp_q <= rx_rp_q + 1'b1;
        end
    end

    // ---------------- RX deframer ----------------
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bits_q  <= '0;
            rx_sh_q    <= '0;
            rx_pbad_q  <= 1'b0;
            rx_push_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_push_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            rx_perr_q <= 1'b0;
            rx_cnt_q  <= rx_cnt_q + 1'b1;
            unique case (rx_state_q)
                RxIdle: begin
                    if (!rx_s2_q) begin
                        rx_state_q <= RxStart;
                        rx_cnt_q   <= '0;
                    end
                end
                RxStart: begin
                    if (rx_cnt_q == HalfLast) begin
                        rx_cnt_q   <= '0;
                        rx_bits_q  <= '0;
                        rx_pbad_q  <= 1'b0;
                        rx_state_q <= rx_s2_q ? RxIdle : RxData;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == DivLast) begin
                        rx_cnt_q  <= '0;
                        rx_sh_q   <= {rx_s2_q, rx_sh_q[7:1]};
                        rx_bits_q <= rx_bits_q + 1'b1;
`ifdef BUART_PARITY_EN
                        if (rx_bits_q == 3'd7) rx_state_q <= RxParity;
`else
                        if (rx_bits_q == 3'd7) rx_state_q <= RxStop;
`endif
                    end
                end
                RxParity: begin
                    if (rx_cnt_q == DivLast) begin
                        rx_cnt_q   <= '0;
                        rx_pbad_q  <= rx_s2_q ^ (^rx_sh_q);
                        rx_state_q <= RxStop;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == DivLast) begin
                        rx_push_q  <= rx_s2_q && !rx_pbad_q;
                        rx_ferr_q  <= !rx_s2_q;
                        rx_perr_q  <= rx_pbad_q;
                        rx_state_q <= RxIdle;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    // ---------------- Sticky errors ----------------
    logic overrun_q, frame_err_q, parity_err_q;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else if (clr_err) begin
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (rx_ovf)    overrun_q    <= 1'b1;
            if (rx_ferr_q) frame_err_q  <= 1'b1;
            if (rx_perr_q) parity_err_q <= 1'b1;
        end
    end

    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
`ifdef BUART_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // ---------------- TX FIFO ----------------
    logic [7:0]             tx_mem_q [TxDepth];
    logic [TX_DEPTH_LOG2:0] tx_wp_q, tx_rp_q;
    logic                   tx_empty, tx_full, tx_wr, tx_pop, tx_bit_end, tx_last;
    logic [7:0]             tx_head;
    logic [FrameBits-1:0]   tx_frame, tx_sh_q;
    tx_state_e              tx_state_q;
    logic [Cw-1:0]          tx_cnt_q;
    logic [3:0]             tx_bits_q;

    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[TX_DEPTH_LOG2] != tx_rp_q[TX_DEPTH_LOG2]) &&
                      (tx_wp_q[TX_DEPTH_LOG2-1:0] == tx_rp_q[TX_DEPTH_LOG2-1:0]);
    assign tx_wr    = wr && !tx_full;
    assign tx_head  = tx_mem_q[tx_rp_q[TX_DEPTH_LOG2-1:0]];
`ifdef BUART_PARITY_EN
    assign tx_frame = {1'b1, ^tx_head, tx_head, 1'b0};
`else
    assign tx_frame = {1'b1, tx_head, 1'b0};
`endif
    assign tx_bit_end = (tx_cnt_q == DivLast);
    assign tx_last    = tx_bit_end && (tx_bits_q == LastBit);
    // Reloading on the stop-bit's final cycle keeps consecutive frames gap-free.
    assign tx_pop     = !tx_empty &&
                        ((tx_state_q == TxIdle) || ((tx_state_q == TxShift) && tx_last));
    assign busy       = tx_full;
    assign tx_idle    = (tx_state_q == TxIdle) && tx_empty;
    assign tx         = tx_sh_q[0];

    always_ff @(posedge clk) begin
        if (tx_wr) tx_mem_q[tx_wp_q[TX_DEPTH_LOG2-1:0]] <= tx_data;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
        end else begin
            if (tx_wr)  tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop) tx_rp_q <= tx_rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state_q <= TxSettle;
            tx_cnt_q   <= '0;
            tx_bits_q  <= '0;
            tx_sh_q    <= '1;
        end else begin
            unique case (tx_state_q)
                TxSettle: begin
                    tx_cnt_q <= tx_cnt_q + 1'b1;
                    if (tx_cnt_q == SettleLast) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= TxIdle;
                    end
                end
                TxIdle: begin
                    if (tx_pop) begin
                        tx_sh_q    <= tx_frame;
                        tx_cnt_q   <= '0;
                        tx_bits_q  <= '0;
                        tx_state_q <= TxShift;
                    end
                end
                TxShift: begin
                    tx_cnt_q <= tx_cnt_q + 1'b1;
                    if (tx_bit_end) begin
                        tx_cnt_q  <= '0;
                        tx_bits_q <= tx_bits_q + 1'b1;
                        tx_sh_q   <= {1'b1, tx_sh_q[FrameBits-1:1]};
                        if (tx_last) begin
                            tx_bits_q <= '0;
                            if (tx_pop) tx_sh_q    <= tx_frame;
                            else        tx_state_q <= TxIdle;
                        end
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_buart_fifo.sv
// Directed self-checking bench for buart_fifo at DIV=104 (12 MHz, 115200 baud), depth 8.
module tb_buart_fifo;
    localparam int Div = 104;
`ifdef BUART_PARITY_EN
    localparam int FrameBits = 11;
`else
    localparam int FrameBits = 10;
`endif

    logic       clk = 1'b0;
    logic       resetq = 1'b1;
    logic       rx = 1'b1;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx, valid, busy, tx_idle, overrun, frame_err, parity_err;
    logic [7:0] rx_data;

    int n_cmp = 0;
    int n_bad = 0;
    int falls = 0;

    buart_fifo dut (
        .clk       (clk),
        .resetq    (resetq),
        .rx        (rx),
        .tx        (tx),
        .wr        (wr),
        .tx_data   (tx_data),
        .rd        (rd),
        .rx_data   (rx_data),
        .valid     (valid),
        .busy      (busy),
        .tx_idle   (tx_idle),
        .overrun   (overrun),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;
    always @(negedge tx) falls = falls + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame on rx; a bad stop bit is low through its middle, then high.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        rx = 1'b0;
        tick(Div);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(Div);
        end
`ifdef BUART_PARITY_EN
        rx = ^d;
        tick(Div);
`endif
        if (stop_ok) begin
            rx = 1'b1;
            tick(Div);
        end else begin
            rx = 1'b0;
            tick(Div * 3 / 4);
            rx = 1'b1;
            tick(Div - Div * 3 / 4);
        end
        tick(2);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        #2 resetq = 1'b0;
        tick(3);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (tx_idle !== 1'b0) begin n_bad++; $display("FAIL reset_tx_idle: got %b want 0", tx_idle); end
        n_cmp++; if ({overrun, frame_err, parity_err} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000", {overrun, frame_err, parity_err});
        end
        resetq = 1'b1;
        tick(15 * Div - 10);
        n_cmp++; if (tx_idle !== 1'b0) begin n_bad++; $display("FAIL settle_busy: got %b want 0", tx_idle); end
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL settle_tx: got %b want 1", tx); end
        tick(20);
        n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL settle_done: got %b want 1", tx_idle); end
    endtask

    task automatic test_rx_basic();
        send_frame(8'h55, 1'b1);
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL rx55_valid: got %b want 1", valid); end
        n_cmp++; if (rx_data !== 8'h55) begin n_bad++; $display("FAIL rx55_data: got %h want 55", rx_data); end
        pulse_rd();
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rx55_pop: got %b want 0", valid); end
        n_cmp++; if ({overrun, frame_err} !== 2'b00) begin
            n_bad++; $display("FAIL rx55_flags: got %b want 00", {overrun, frame_err});
        end
    endtask

    task automatic test_tx_basic();
        logic [7:0] d;
        d = 8'hA3;
        wr = 1'b1;
        tx_data = d;
        tick(1);
        wr = 1'b0;
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL tx_n1: got %b want 1", tx); end
        tick(1);
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL tx_n2_start: got %b want 0", tx); end
        tick(Div / 2);
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL tx_start_mid: got %b want 0", tx); end
        n_cmp++; if (tx_idle !== 1'b0) begin n_bad++; $display("FAIL tx_idle_busy: got %b want 0", tx_idle); end
        for (int i = 0; i < 8; i++) begin
            tick(Div);
            n_cmp++; if (tx !== d[i]) begin
                n_bad++; $display("FAIL tx_bit%0d: got %b want %b", i, tx, d[i]);
            end
        end
`ifdef BUART_PARITY_EN
        tick(Div);
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL tx_parity: got %b want 0", tx); end
`endif
        tick(Div);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL tx_stop: got %b want 1", tx); end
        tick(Div);
        n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL tx_idle_after: got %b want 1", tx_idle); end
    endtask

    task automatic test_glitch_frame();
        rx = 1'b0;
        tick(30);
        rx = 1'b1;
        tick(2 * Div);
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL glitch_valid: got %b want 0", valid); end
        n_cmp++; if ({overrun, frame_err, parity_err} !== 3'b000) begin
            n_bad++; $display("FAIL glitch_flags: got %b want 000", {overrun, frame_err, parity_err});
        end
        send_frame(8'h7E, 1'b0);
        tick(Div);
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_set: got %b want 1", frame_err); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL ferr_nopush: got %b want 0", valid); end
        send_frame(8'h3C, 1'b1);
        n_cmp++; if (rx_data !== 8'h3C || valid !== 1'b1) begin
            n_bad++; $display("FAIL recover_data: got %h/%b want 3c/1", rx_data, valid);
        end
        pulse_rd();
        pulse_clr();
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_clr: got %b want 0", frame_err); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1);
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid: got %b want 1", valid); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (rx_data !== 8'(i)) begin
                n_bad++; $display("FAIL ovr_read%0d: got %h want %h", i, rx_data, 8'(i));
            end
            pulse_rd();
        end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL ovr_drained: got %b want 0", valid); end
        pulse_clr();
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clr: got %b want 0", overrun); end
    endtask

    // 0xFE gives exactly one falling edge per frame, with or without parity.
    task automatic test_back_to_back();
        int base;
        int cnt;
        base = falls;
        wr = 1'b1;
        tx_data = 8'hFE;
        tick(1);
        wr = 1'b0;
        tick(1);
        for (int i = 0; i < 9; i++) begin
            wr = 1'b1;
            tick(1);
            if (i == 6) begin
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy7: got %b want 0", busy); end
            end
            if (i == 7) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy8: got %b want 1", busy); end
            end
        end
        wr = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy9: got %b want 1", busy); end
        cnt = 0;
        while (tx_idle !== 1'b1 && cnt < 12000) begin
            tick(1);
            cnt++;
        end
        n_cmp++; if (cnt != 9 * FrameBits * Div - 9) begin
            n_bad++; $display("FAIL b2b_duration: got %0d want %0d", cnt, 9 * FrameBits * Div - 9);
        end
        n_cmp++; if (falls - base != 9) begin
            n_bad++; $display("FAIL b2b_frames: got %0d want 9", falls - base);
        end
    endtask

    task automatic test_parity();
`ifdef BUART_PARITY_EN
        logic [7:0] d;
        d = 8'h07;
        rx = 1'b0;
        tick(Div);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(Div);
        end
        rx = 1'b0;
        tick(Div);
        rx = 1'b1;
        tick(Div + 2);
        n_cmp++; if (parity_err !== 1'b1) begin n_bad++; $display("FAIL par_set: got %b want 1", parity_err); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL par_nopush: got %b want 0", valid); end
        pulse_clr();
        send_frame(d, 1'b1);
        n_cmp++; if (valid !== 1'b1 || rx_data !== 8'h07) begin
            n_bad++; $display("FAIL par_good: got %b/%h want 1/07", valid, rx_data);
        end
        pulse_rd();
`else
        send_frame(8'h81, 1'b1);
        n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL par_tied: got %b want 0", parity_err); end
        n_cmp++; if (rx_data !== 8'h81) begin n_bad++; $display("FAIL par_off_data: got %h want 81", rx_data); end
        pulse_rd();
`endif
    endtask

    task automatic test_reset_mid();
        wr = 1'b1;
        tx_data = 8'h00;
        tick(1);
        wr = 1'b0;
        tick(3 * Div);
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL mid_frame_tx: got %b want 0", tx); end
        resetq = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL mid_reset_tx: got %b want 1", tx); end
        tick(2);
        resetq = 1'b1;
        tick(15 * Div - 10);
        n_cmp++; if (tx_idle !== 1'b0 || tx !== 1'b1) begin
            n_bad++; $display("FAIL mid_settle: got %b/%b want 0/1", tx_idle, tx);
        end
        tick(20);
        n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL mid_settle_done: got %b want 1", tx_idle); end
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_tx_basic();
        test_glitch_frame();
        test_overrun();
        test_back_to_back();
        test_parity();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
